icon_bar_display: RTL and testbench

ICON_BAR_DISPLAY -- requirements
Module: icon_bar_display

---
 rtl/hud_pkg.sv | 18 +
 rtl/icon_bar_display_if.sv | 36 +++
 rtl/icon_bar_blink.sv | 94 +++++++++
 rtl/icon_bar_display.sv | 105 ++++++++++
 tb/tb_icon_bar_display.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/hud_pkg.sv
// Shared HUD definitions for the icon bar display.
// Holds the per-bar blink FSM state type, the default icon geometry and a small
// count-clamping helper used by the bar FSMs.
package hud_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BLINK = 1'b1
    } bar_state_e;

    localparam int unsigned DEF_ICON_W = 16;
    localparam int unsigned DEF_ICON_H = 16;

    function automatic int unsigned clamp_count(int unsigned value, int unsigned max_count);
        return (value > max_count) ? max_count : value;
    endfunction

endpackage

// File: rtl/icon_bar_display_if.sv
// Pixel-side bus of the icon bar display.
// master: drives frame pulse, per-bar counts and scan position; receives draw info.
// slave : the display block.
//   startOfFrame  one-cycle pulse at the start of each frame
//   count         per-bar icon count, NUM_BARS x COUNT_W
//   pixelX/Y      current scan pixel (11 bits each)
//   drawReq       pixel lies inside a visible icon (registered, 1 clk later)
//   offsetX/Y     pixel offset inside the icon
//   barId         bar being drawn
//   lostIcon      drawn icon is a blinking lost icon
interface icon_bar_display_if #(
    parameter int unsigned NUM_BARS = 2,
    parameter int unsigned COUNT_W  = 3
) ();
    localparam int unsigned BAR_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

    logic                              startOfFrame;
    logic [NUM_BARS-1:0][COUNT_W-1:0]  count;
    logic [10:0]                       pixelX;
    logic [10:0]                       pixelY;
    logic                              drawReq;
    logic [10:0]                       offsetX;
    logic [10:0]                       offsetY;
    logic [BAR_W-1:0]                  barId;
    logic                              lostIcon;

    modport master (
        output startOfFrame, count, pixelX, pixelY,
        input  drawReq, offsetX, offsetY, barId, lostIcon
    );

    modport slave (
        input  startOfFrame, count, pixelX, pixelY,
        output drawReq, offsetX, offsetY, barId, lostIcon
    );
endinterface

// File: rtl/icon_bar_blink.sv
// Per-bar count tracker and lost-icon blink FSM.
// Samples count only on start-of-frame; a drop in count makes the lost icons
// blink for BLINK_FRAMES frames before they disappear.
//   clk_i, reset_i  clock, synchronous active-high reset
//   sof_i           start-of-frame pulse
//   count_i         raw count for this bar (clamped to MAX_COUNT internally)
//   state_o         IDLE / BLINK
//   shown_o         icons currently occupying the bar (incl. blinking ones)
//   floor_o         icons that stay solid while blinking
//   phase_o         1 = lost icons visible in this blink half-phase
module icon_bar_blink
    import hud_pkg::*;
#(
    parameter int unsigned COUNT_W      = 3,
    parameter int unsigned MAX_COUNT    = 7,
    parameter int unsigned BLINK_FRAMES = 60,
    parameter int unsigned BLINK_PERIOD = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               sof_i,
    input  logic [COUNT_W-1:0] count_i,
    output bar_state_e         state_o,
    output logic [COUNT_W-1:0] shown_o,
    output logic [COUNT_W-1:0] floor_o,
    output logic               phase_o
);
    localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned PC_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    logic [COUNT_W-1:0] eff;
    logic [FC_W-1:0]    frame_q;
    logic [PC_W-1:0]    period_q;

    always_comb begin
        eff = COUNT_W'(clamp_count(32'(count_i), MAX_COUNT));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_o  <= IDLE;
            shown_o  <= '0;
            floor_o  <= '0;
            frame_q  <= '0;
            period_q <= '0;
            phase_o  <= 1'b0;
        end else if (sof_i) begin
            unique case (state_o)
                IDLE: begin
                    if (eff >= shown_o) begin
                        shown_o <= eff;
                    end else begin
                        floor_o  <= eff;
                        state_o  <= BLINK;
                        frame_q  <= '0;
                        period_q <= '0;
                        phase_o  <= 1'b1;
                    end
                end
                BLINK: begin
                    if (eff > floor_o) begin
                        // Count recovered: drop the blink and show the new count.
                        shown_o  <= eff;
                        state_o  <= IDLE;
                        frame_q  <= '0;
                        period_q <= '0;
                        phase_o  <= 1'b0;
                    end else if (eff < floor_o) begin
                        // Further loss: widen the blinking range, restart timing.
                        floor_o  <= eff;
                        frame_q  <= '0;
                        period_q <= '0;
                        phase_o  <= 1'b1;
                    end else if (frame_q == FC_W'(BLINK_FRAMES - 1)) begin
                        shown_o  <= floor_o;
                        state_o  <= IDLE;
                        frame_q  <= '0;
                        period_q <= '0;
                        phase_o  <= 1'b0;
                    end else begin
                        frame_q <= frame_q + 1'b1;
                        if (period_q == PC_W'(BLINK_PERIOD - 1)) begin
                            period_q <= '0;
                            phase_o  <= ~phase_o;
                        end else begin
                            period_q <= period_q + 1'b1;
                        end
                    end
                end
                default: state_o <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/icon_bar_display.sv
// HUD icon bar renderer: NUM_BARS rows of up to MAX_COUNT icons each.
// Per-bar counting/blinking lives in icon_bar_blink; this module does the pixel
// hit-test and registers all outputs (1 clk after pixelX/pixelY).
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    icon_bar_display_if slave: frame pulse, counts, scan pixel in;
//          drawReq, offsetX/Y, barId, lostIcon out
module icon_bar_display
    import hud_pkg::*;
#(
    parameter int unsigned NUM_BARS     = 2,
    parameter int unsigned COUNT_W      = 3,
    parameter int unsigned MAX_COUNT    = 7,
    parameter int unsigned ICON_W       = DEF_ICON_W,
    parameter int unsigned ICON_H       = DEF_ICON_H,
    parameter int          TLX          = 10,
    parameter int          TLY          = 40,
    parameter int unsigned ROW_PITCH    = 20,
    parameter int unsigned BLINK_FRAMES = 60,
    parameter int unsigned BLINK_PERIOD = 8
) (
    input  logic               clk,
    input  logic               reset,
    icon_bar_display_if.slave  bus
);
    localparam int unsigned BAR_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

    bar_state_e         state     [NUM_BARS];
    logic [COUNT_W-1:0] shown_cnt [NUM_BARS];
    logic [COUNT_W-1:0] floor_cnt [NUM_BARS];
    logic               phase     [NUM_BARS];

    for (genvar b = 0; b < NUM_BARS; b++) begin : g_bar
        icon_bar_blink #(
            .COUNT_W      (COUNT_W),
            .MAX_COUNT    (MAX_COUNT),
            .BLINK_FRAMES (BLINK_FRAMES),
            .BLINK_PERIOD (BLINK_PERIOD)
        ) u_blink (
            .clk_i   (clk),
            .reset_i (reset),
            .sof_i   (bus.startOfFrame),
            .count_i (bus.count[b]),
            .state_o (state[b]),
            .shown_o (shown_cnt[b]),
            .floor_o (floor_cnt[b]),
            .phase_o (phase[b])
        );
    end

    logic             hit_d;
    logic             lost_d;
    logic [10:0]      off_x_d;
    logic [10:0]      off_y_d;
    logic [BAR_W-1:0] bar_d;
    int               rel_x;
    int               rel_y;
    int               idx;
    int               solid_lim;

    // 32-bit signed arithmetic: no wrap for pixels left of / above the bars.
    always_comb begin
        hit_d     = 1'b0;
        lost_d    = 1'b0;
        off_x_d   = '0;
        off_y_d   = '0;
        bar_d     = '0;
        rel_x     = int'(bus.pixelX) - TLX;
        rel_y     = 0;
        idx       = 0;
        solid_lim = 0;
        // Descending so the lowest matching bar is written last and wins.
        for (int b = NUM_BARS - 1; b >= 0; b--) begin
            rel_y = int'(bus.pixelY) - (TLY + b * int'(ROW_PITCH));
            if (rel_x >= 0 && rel_y >= 0 && rel_y < int'(ICON_H)) begin
                idx       = rel_x / int'(ICON_W);
                solid_lim = (state[b] == BLINK) ? int'(floor_cnt[b]) : int'(shown_cnt[b]);
                if (idx < solid_lim ||
                    (state[b] == BLINK && phase[b] && idx < int'(shown_cnt[b]))) begin
                    hit_d   = 1'b1;
                    lost_d  = (idx >= solid_lim);
                    off_x_d = 11'(rel_x - idx * int'(ICON_W));
                    off_y_d = 11'(rel_y);
                    bar_d   = BAR_W'(b);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.drawReq  <= 1'b0;
            bus.offsetX  <= '0;
            bus.offsetY  <= '0;
            bus.barId    <= '0;
            bus.lostIcon <= 1'b0;
        end else begin
            bus.drawReq  <= hit_d;
            bus.offsetX  <= off_x_d;
            bus.offsetY  <= off_y_d;
            bus.barId    <= bar_d;
            bus.lostIcon <= lost_d;
        end
    end
endmodule

// File: tb/tb_icon_bar_display.sv
// Randomized scoreboard bench for icon_bar_display. The driver pushes the
// expected output of each cycle into a queue; a negedge monitor pops and checks.
module tb_icon_bar_display;
    localparam int NB   = 2;
    localparam int CW   = 4;
    localparam int MAXC = 7;
    localparam int IW   = 16;
    localparam int IH   = 16;
    localparam int TLX  = 10;
    localparam int TLY  = 40;
    localparam int RP   = 20;
    localparam int BF   = 60;
    localparam int BP   = 8;
    localparam int FRAME_LEN = 16;

    typedef struct {
        bit draw;
        int ox;
        int oy;
        int bar;
        bit lost;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icon_bar_display_if #(.NUM_BARS(NB), .COUNT_W(CW)) bus ();

    icon_bar_display #(
        .NUM_BARS(NB), .COUNT_W(CW), .MAX_COUNT(MAXC), .ICON_W(IW), .ICON_H(IH),
        .TLX(TLX), .TLY(TLY), .ROW_PITCH(RP), .BLINK_FRAMES(BF), .BLINK_PERIOD(BP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [CW-1:0] cnt_v [NB];

    // Reference model: bar contents per spec rules, blink timing by frame age.
    int m_shown [NB];
    int m_floor [NB];
    int m_start [NB];
    bit m_blink [NB];
    int frame_no = 0;

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            m_shown[b] = 0;
            m_floor[b] = 0;
            m_start[b] = 0;
            m_blink[b] = 0;
        end
    endfunction

    function automatic void model_frame();
        int e;
        frame_no++;
        for (int b = 0; b < NB; b++) begin
            e = (int'(cnt_v[b]) > MAXC) ? MAXC : int'(cnt_v[b]);
            if (!m_blink[b]) begin
                if (e >= m_shown[b]) m_shown[b] = e;
                else begin
                    m_floor[b] = e;
                    m_blink[b] = 1;
                    m_start[b] = frame_no;
                end
            end else if (e > m_floor[b]) begin
                m_shown[b] = e;
                m_blink[b] = 0;
            end else if (e < m_floor[b]) begin
                m_floor[b] = e;
                m_start[b] = frame_no;
            end else if (frame_no - m_start[b] >= BF) begin
                m_shown[b] = m_floor[b];
                m_blink[b] = 0;
            end
        end
    endfunction

    function automatic exp_t model_pixel(int px, int py);
        exp_t r;
        int top, i, solid;
        bit vis;
        r = '{draw: 0, ox: 0, oy: 0, bar: 0, lost: 0};
        for (int b = 0; b < NB; b++) begin
            top = TLY + b * RP;
            if (!r.draw && py >= top && py < top + IH && px >= TLX) begin
                i     = (px - TLX) / IW;
                vis   = (((frame_no - m_start[b]) / BP) % 2) == 0;
                solid = m_blink[b] ? m_floor[b] : m_shown[b];
                if (i < solid || (m_blink[b] && vis && i < m_shown[b])) begin
                    r.draw = 1;
                    r.lost = (i >= solid);
                    r.ox   = (px - TLX) % IW;
                    r.oy   = py - top;
                    r.bar  = b;
                end
            end
        end
        return r;
    endfunction

    task automatic step(input bit sof, input bit rst, input int px, input int py);
        exp_t e;
        reset            = rst;
        bus.startOfFrame = sof;
        bus.pixelX       = 11'(px);
        bus.pixelY       = 11'(py);
        for (int b = 0; b < NB; b++) bus.count[b] = cnt_v[b];
        if (rst) begin
            e = '{draw: 0, ox: 0, oy: 0, bar: 0, lost: 0};
            model_reset();
        end else begin
            e = model_pixel(px, py);
            if (sof) model_frame();
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic pick_pixel(output int px, output int py);
        int b;
        if ($urandom_range(0, 3) == 0) begin
            px = int'($urandom_range(0, 2047));
            py = int'($urandom_range(0, 2047));
        end else begin
            b  = int'($urandom_range(0, NB - 1));
            py = TLY + b * RP - 2 + int'($urandom_range(0, IH + 3));
            px = TLX - 3 + int'($urandom_range(0, MAXC * IW + 40));
        end
    endtask

    // rand_cnt: occasionally change a bar count at an arbitrary cycle.
    task automatic run_frames(input int n, input bit rand_cnt);
        int px, py;
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < FRAME_LEN; c++) begin
                if (rand_cnt && $urandom_range(0, 299) == 0)
                    cnt_v[$urandom_range(0, NB - 1)] = CW'($urandom_range(0, 15));
                pick_pixel(px, py);
                step(c == 0, 1'b0, px, py);
            end
        end
    endtask

    // Monitor: one DUT output per cycle, checked against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (bus.drawReq !== e.draw || int'(bus.offsetX) != e.ox ||
                    int'(bus.offsetY) != e.oy || int'(bus.barId) != e.bar ||
                    bus.lostIcon !== e.lost) begin
                    n_fail++;
                    $display("FAIL pixel_out @%0t: got draw=%0b ox=%0d oy=%0d bar=%0d lost=%0b, exp draw=%0b ox=%0d oy=%0d bar=%0d lost=%0b",
                             $time, bus.drawReq, bus.offsetX, bus.offsetY, bus.barId,
                             bus.lostIcon, e.draw, e.ox, e.oy, e.bar, e.lost);
                end
            end
        end
    end

    initial begin
        int px, py;
        for (int b = 0; b < NB; b++) cnt_v[b] = '0;
        model_reset();
        repeat (3) step(1'b0, 1'b1, TLX + 5, TLY + 5);

        // Basic draw and right edge of a 3-icon bar.
        cnt_v[0] = 4'd3;
        run_frames(1, 1'b0);
        step(1'b0, 1'b0, TLX + 40, TLY + 5);
        step(1'b0, 1'b0, TLX + 48, TLY + 5);
        step(1'b0, 1'b0, TLX + 47, TLY + 15);
        step(1'b0, 1'b0, TLX - 1, TLY + 5);

        // Full blink 3->2 and timeout.
        cnt_v[0] = 4'd2;
        run_frames(70, 1'b0);

        // Blink cancelled by a rise to 4.
        cnt_v[0] = 4'd3;
        run_frames(2, 1'b0);
        cnt_v[0] = 4'd2;
        run_frames(5, 1'b0);
        cnt_v[0] = 4'd4;
        run_frames(3, 1'b0);

        // Clamp on bar 1.
        cnt_v[1] = 4'd9;
        run_frames(3, 1'b0);
        step(1'b0, 1'b0, TLX + 6 * IW + 3, TLY + RP + 2);
        step(1'b0, 1'b0, TLX + 7 * IW + 3, TLY + RP + 2);

        // Reset in the middle of a blink, then reload with no blink.
        cnt_v[0] = 4'd1;
        run_frames(3, 1'b0);
        step(1'b0, 1'b1, TLX + 3, TLY + 3);
        step(1'b0, 1'b1, TLX + 3, TLY + 3);
        cnt_v[0] = 4'd5;
        run_frames(3, 1'b0);

        // Mid-frame count change is ignored until the next frame start.
        step(1'b1, 1'b0, TLX + 3, TLY + 3);
        cnt_v[0] = 4'd1;
        for (int c = 1; c < FRAME_LEN; c++) begin
            pick_pixel(px, py);
            step(1'b0, 1'b0, px, py);
        end
        run_frames(2, 1'b0);

        // Random phase with occasional short resets.
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                repeat ($urandom_range(1, 2)) step(1'b0, 1'b1, TLX, TLY);
            end
            run_frames(1, 1'b1);
        end

        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
